// File: rtl/decode_stage_hazard_if.sv
// decode_stage_hazard_if: IF/WB/EX-facing signals of the decode stage, grouped for the ID/EX boundary
interface decode_stage_hazard_if #(
    parameter int B = 32,
    parameter int W = 5
);
    logic         if_valid;
    logic [B-1:0] instruction;
    logic [B-1:0] pc_incrementado_in;
    logic         RegWrite;
    logic [W-1:0] address_write;
    logic [B-1:0] data_write;
    logic         ex_flush;
    logic         stall_if;
    logic         id_valid;
    logic [B-1:0] pc_incrementado_out;
    logic [B-1:0] reg_data1;
    logic [B-1:0] reg_data2;
    logic [B-1:0] sgn_extend_data_imm;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] rd;
    logic         wb_RegWrite_out;
    logic         wb_MemtoReg_out;
    logic         m_Branch_out;
    logic         m_MemRead_out;
    logic         m_MemWrite_out;
    logic         ex_RegDst_out;
    logic         ex_ALUSrc_out;
    logic [1:0]   ex_ALUOp_out;
    logic         illegal_op_out;

    modport master (
        output if_valid, instruction, pc_incrementado_in, RegWrite, address_write, data_write, ex_flush,
        input  stall_if, id_valid, pc_incrementado_out, reg_data1, reg_data2, sgn_extend_data_imm,
               rs, rt, rd, wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_MemRead_out,
               m_MemWrite_out, ex_RegDst_out, ex_ALUSrc_out, ex_ALUOp_out, illegal_op_out
    );

    modport slave (
        input  if_valid, instruction, pc_incrementado_in, RegWrite, address_write, data_write, ex_flush,
        output stall_if, id_valid, pc_incrementado_out, reg_data1, reg_data2, sgn_extend_data_imm,
               rs, rt, rd, wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_MemRead_out,
               m_MemWrite_out, ex_RegDst_out, ex_ALUSrc_out, ex_ALUOp_out, illegal_op_out
    );
endinterface

// File: rtl/decode_stage_hazard.sv
// decode_stage_hazard: MIPS-style ID stage with register file, control decode, load-use stall and ID/EX register
module decode_stage_hazard #(
    parameter int B = 32,
    parameter int W = 5
) (
    input logic                 clk,
    input logic                 reset,
    decode_stage_hazard_if.slave bus
);
    localparam int N = 2 ** W;
    logic [B-1:0] regs [N];
    logic [5:0]   opcode;
    logic [W-1:0] rs_a, rt_a, rd_a;
    logic [B-1:0] rd1, rd2, imm;
    logic         is_r, is_lw, is_sw, is_beq, known, uses_rt, v, load_use, bubble;

    assign opcode  = bus.instruction[31:26];
    assign rs_a    = W'(bus.instruction[25:21]);
    assign rt_a    = W'(bus.instruction[20:16]);
    assign rd_a    = W'(bus.instruction[15:11]);
    assign is_r    = opcode == 6'b000000;
    assign is_lw   = opcode == 6'b100011;
    assign is_sw   = opcode == 6'b101011;
    assign is_beq  = opcode == 6'b000100;
    assign known   = is_r | is_lw | is_sw | is_beq;
    assign uses_rt = is_r | is_sw | is_beq;
    assign v       = bus.if_valid;
    assign imm     = {{(B-16){bus.instruction[15]}}, bus.instruction[15:0]};

    // a nonzero read address matching the WB address implies address_write != 0
    assign rd1 = rs_a == '0 ? '0 : (bus.RegWrite && bus.address_write == rs_a) ? bus.data_write : regs[rs_a];
    assign rd2 = rt_a == '0 ? '0 : (bus.RegWrite && bus.address_write == rt_a) ? bus.data_write : regs[rt_a];

    assign load_use = bus.id_valid & bus.m_MemRead_out & (bus.rt != '0) & v &
                      ((bus.rt == rs_a) | ((bus.rt == rt_a) & uses_rt));
    assign bus.stall_if = load_use & ~bus.ex_flush;
    assign bubble = bus.ex_flush | bus.stall_if;

    always_ff @(posedge clk) begin
        if (reset)
            for (int i = 0; i < N; i++) regs[i] <= '0;
        else if (bus.RegWrite && bus.address_write != '0)
            regs[bus.address_write] <= bus.data_write;
    end

    // flush and stall both insert a fully cleared bubble
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            bus.id_valid            <= 1'b0;
            bus.pc_incrementado_out <= '0;
            bus.reg_data1           <= '0;
            bus.reg_data2           <= '0;
            bus.sgn_extend_data_imm <= '0;
            bus.rs                  <= '0;
            bus.rt                  <= '0;
            bus.rd                  <= '0;
            bus.wb_RegWrite_out     <= 1'b0;
            bus.wb_MemtoReg_out     <= 1'b0;
            bus.m_Branch_out        <= 1'b0;
            bus.m_MemRead_out       <= 1'b0;
            bus.m_MemWrite_out      <= 1'b0;
            bus.ex_RegDst_out       <= 1'b0;
            bus.ex_ALUSrc_out       <= 1'b0;
            bus.ex_ALUOp_out        <= 2'b00;
            bus.illegal_op_out      <= 1'b0;
        end else begin
            bus.id_valid            <= v;
            bus.pc_incrementado_out <= bus.pc_incrementado_in;
            bus.reg_data1           <= rd1;
            bus.reg_data2           <= rd2;
            bus.sgn_extend_data_imm <= imm;
            bus.rs                  <= rs_a;
            bus.rt                  <= rt_a;
            bus.rd                  <= rd_a;
            bus.wb_RegWrite_out     <= v & (is_r | is_lw);
            bus.wb_MemtoReg_out     <= v & is_lw;
            bus.m_Branch_out        <= v & is_beq;
            bus.m_MemRead_out       <= v & is_lw;
            bus.m_MemWrite_out      <= v & is_sw;
            bus.ex_RegDst_out       <= v & is_r;
            bus.ex_ALUSrc_out       <= v & (is_lw | is_sw);
            bus.ex_ALUOp_out        <= v ? {is_r, is_beq} : 2'b00;
            bus.illegal_op_out      <= v & ~known;
        end
    end
endmodule

// File: tb/tb_decode_stage_hazard.sv
// tb_decode_stage_hazard: directed plus random checks of the decode stage against a behavioural model
module tb_decode_stage_hazard;
    localparam int B = 32;
    localparam int W = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_stage_hazard_if #(.B(B), .W(W)) bus ();
    decode_stage_hazard #(.B(B), .W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    logic seen_stall;

    logic [B-1:0] mregs [32];
    logic         mv, m_rw, m_m2r, m_br, m_mr, m_mw, m_dst, m_src, m_ill;
    logic [1:0]   m_aluop;
    logic [B-1:0] m_pc, m_d1, m_d2, m_imm;
    logic [W-1:0] m_rs, m_rt, m_rd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void clear_model();
        mv = 0; m_rw = 0; m_m2r = 0; m_br = 0; m_mr = 0; m_mw = 0; m_dst = 0; m_src = 0; m_ill = 0;
        m_aluop = 0; m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_rd = 0;
    endfunction

    function automatic logic [B-1:0] mread(input logic [4:0] a);
        if (a == 0) return '0;
        if (bus.RegWrite && bus.address_write == a) return bus.data_write;
        return mregs[a];
    endfunction

    function automatic logic exp_stall();
        logic [5:0] op;
        logic uses;
        op = bus.instruction[31:26];
        uses = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        if (bus.ex_flush || !mv || !m_mr || m_rt == 0 || !bus.if_valid) return 1'b0;
        return (m_rt == bus.instruction[25:21]) || (uses && m_rt == bus.instruction[20:16]);
    endfunction

    task automatic check_all();
        check("id_valid", bus.id_valid, mv);
        check("pc", bus.pc_incrementado_out, m_pc);
        check("reg_data1", bus.reg_data1, m_d1);
        check("reg_data2", bus.reg_data2, m_d2);
        check("imm", bus.sgn_extend_data_imm, m_imm);
        check("rs", bus.rs, m_rs);
        check("rt", bus.rt, m_rt);
        check("rd", bus.rd, m_rd);
        check("RegWrite", bus.wb_RegWrite_out, m_rw);
        check("MemtoReg", bus.wb_MemtoReg_out, m_m2r);
        check("Branch", bus.m_Branch_out, m_br);
        check("MemRead", bus.m_MemRead_out, m_mr);
        check("MemWrite", bus.m_MemWrite_out, m_mw);
        check("RegDst", bus.ex_RegDst_out, m_dst);
        check("ALUSrc", bus.ex_ALUSrc_out, m_src);
        check("ALUOp", bus.ex_ALUOp_out, m_aluop);
        check("illegal", bus.illegal_op_out, m_ill);
    endtask

    // inputs are set at a negedge; the task checks stall, advances the model and checks the registered outputs
    task automatic step();
        logic s;
        logic [31:0] ins;
        #1;
        s = exp_stall();
        seen_stall = bus.stall_if;
        check("stall_if", bus.stall_if, s);
        ins = bus.instruction;
        if (reset) begin
            clear_model();
            for (int i = 0; i < 32; i++) mregs[i] = '0;
        end else begin
            if (bus.ex_flush || s) clear_model();
            else begin
                clear_model();
                mv = bus.if_valid;
                m_pc = bus.pc_incrementado_in;
                m_d1 = mread(ins[25:21]);
                m_d2 = mread(ins[20:16]);
                m_imm = {{16{ins[15]}}, ins[15:0]};
                m_rs = ins[25:21];
                m_rt = ins[20:16];
                m_rd = ins[15:11];
                if (bus.if_valid)
                    case (ins[31:26])
                        6'h00: begin m_rw = 1; m_dst = 1; m_aluop = 2'b10; end
                        6'h23: begin m_rw = 1; m_m2r = 1; m_mr = 1; m_src = 1; end
                        6'h2B: begin m_mw = 1; m_src = 1; end
                        6'h04: begin m_br = 1; m_aluop = 2'b01; end
                        default: m_ill = 1;
                    endcase
            end
            if (bus.RegWrite && bus.address_write != 0) mregs[bus.address_write] = bus.data_write;
        end
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic set_ins(input logic [31:0] ins);
        bus.instruction = ins;
        bus.pc_incrementado_in = $urandom();
        bus.if_valid = 1;
        bus.RegWrite = 0;
        bus.ex_flush = 0;
        reset = 0;
    endtask

    function automatic logic [31:0] rand_ins();
        logic [5:0] op;
        case ($urandom_range(0, 4))
            0: op = 6'h00;
            1: op = 6'h23;
            2: op = 6'h2B;
            3: op = 6'h04;
            default: op = 6'($urandom_range(0, 63));
        endcase
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom())};
    endfunction

    initial begin
        clear_model();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        reset = 1;
        bus.if_valid = 0;
        bus.instruction = 0;
        bus.pc_incrementado_in = 0;
        bus.RegWrite = 0;
        bus.address_write = 0;
        bus.data_write = 0;
        bus.ex_flush = 1;
        step();
        bus.ex_flush = 0;
        step();
        check("reset_valid", bus.id_valid, 1'b0);

        set_ins({6'd0, 5'd3, 5'd0, 5'd1, 5'd0, 6'h20});
        bus.RegWrite = 1; bus.address_write = 3; bus.data_write = 32'hDEADBEEF;
        step();
        check("bypass_d1", bus.reg_data1, 32'hDEADBEEF);
        check("bypass_ALUOp", bus.ex_ALUOp_out, 2'b10);

        set_ins({6'd0, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20});
        bus.RegWrite = 1; bus.address_write = 0; bus.data_write = 32'h12345678;
        step();
        set_ins({6'd0, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20});
        step();
        check("r0_zero", bus.reg_data1, 32'h0);

        set_ins({6'h23, 5'd1, 5'd2, 16'd4});
        step();
        set_ins({6'd0, 5'd2, 5'd5, 5'd4, 5'd0, 6'h20});
        step();
        check("lu_stall", seen_stall, 1'b1);
        check("lu_bubble", bus.id_valid, 1'b0);
        step();
        check("lu_release", seen_stall, 1'b0);
        check("lu_issue", bus.id_valid, 1'b1);

        set_ins({6'h23, 5'd1, 5'd2, 16'd4});
        step();
        set_ins({6'h2B, 5'd7, 5'd2, 16'd0});
        step();
        check("sw_stall", seen_stall, 1'b1);
        step();

        set_ins({6'h23, 5'd1, 5'd2, 16'd4});
        step();
        set_ins({6'h08, 5'd5, 5'd2, 16'd1});
        step();
        check("addi_nostall", seen_stall, 1'b0);

        set_ins({6'h23, 5'd1, 5'd2, 16'd4});
        step();
        set_ins({6'h04, 5'd2, 5'd3, 16'd8});
        bus.ex_flush = 1;
        step();
        check("flush_nostall", seen_stall, 1'b0);
        check("flush_valid", bus.id_valid, 1'b0);
        check("flush_branch", bus.m_Branch_out, 1'b0);

        set_ins(32'h8C22FFFC);
        step();
        check("lw_imm", bus.sgn_extend_data_imm, 32'hFFFFFFFC);
        check("lw_memread", bus.m_MemRead_out, 1'b1);
        set_ins({6'h3F, 26'd0});
        step();
        check("ill_flag", bus.illegal_op_out, 1'b1);
        check("ill_regwrite", bus.wb_RegWrite_out, 1'b0);

        set_ins(32'h0);
        bus.if_valid = 0; bus.RegWrite = 1; bus.address_write = 5; bus.data_write = 32'hCAFEF00D;
        step();
        set_ins({6'd0, 5'd5, 5'd0, 5'd1, 5'd0, 6'h20});
        reset = 1;
        step();
        check("midreset_valid", bus.id_valid, 1'b0);
        set_ins({6'd0, 5'd5, 5'd0, 5'd1, 5'd0, 6'h20});
        step();
        check("midreset_r5", bus.reg_data1, 32'h0);

        for (int i = 0; i < 2000; i++) begin
            reset = $urandom_range(0, 99) == 0;
            if (!seen_stall) begin
                bus.instruction = rand_ins();
                bus.pc_incrementado_in = $urandom();
                bus.if_valid = $urandom_range(0, 9) != 0;
            end
            bus.ex_flush = $urandom_range(0, 9) == 0;
            bus.RegWrite = 1'($urandom_range(0, 1));
            bus.address_write = 5'($urandom_range(0, 7));
            bus.data_write = $urandom();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage_hazard.md
Name: decode_stage_hazard

Overview:
- Parametrised MIPS-style instruction-decode stage with an integrated ID/EX pipeline register.
- Contains the 2^W x B register file with write-through bypass, main control decode and sign extension.
- Detects load-use hazards and stalls IF for one cycle; accepts a branch flush from EX.
- Sits between the IF/ID register and the execute stage; all EX-facing outputs are registered, with 1-cycle latency.

Parameters:
B, 32, data/instruction word width (B >= 32)
W, 5, register address width; register file depth = 2^W

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_valid  in  1  instruction/pc_incrementado_in hold a valid instruction
instruction  in  B  instruction word from IF/ID
pc_incrementado_in  in  B  PC+4 from IF
RegWrite  in  1  WB write enable
address_write  in  W  WB destination register
data_write  in  B  WB write data
ex_flush  in  1  branch taken in EX; squash the instruction in ID
stall_if  out  1  combinational; hold PC and IF/ID this cycle
id_valid  out  1  ID/EX register holds a valid instruction
pc_incrementado_out  out  B  registered PC+4
reg_data1, reg_data2  out  B  registered rs/rt read data
sgn_extend_data_imm  out  B  registered sign-extended instruction[15:0]
rs, rt, rd  out  W  registered instruction[25:21], [20:16], [15:11] (zero-extended/truncated to W)
wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_MemRead_out, m_MemWrite_out, ex_RegDst_out, ex_ALUSrc_out  out  1  registered control
ex_ALUOp_out  out  2  registered ALU op class
illegal_op_out  out  1  registered; unsupported opcode in a valid slot

Behaviour:
Reset:
- On reset=1 at a clk edge, every registered output is 0 and id_valid=0.
- All register-file entries are cleared to 0.
- stall_if=0 while id_valid=0.

Register file:
- Write at posedge when RegWrite=1 and address_write!=0.
- Register 0 always reads 0.
- Reads are combinational.
- Bypass: if RegWrite=1, address_write!=0 and address_write equals the read address, read data = data_write in the same cycle.

Decode (opcode = instruction[31:26]):
- 000000 R-type: RegWrite=1, RegDst=1, ALUOp=10.
- 100011 lw: RegWrite=1, MemtoReg=1, MemRead=1, ALUSrc=1, ALUOp=00.
- 101011 sw: MemWrite=1, ALUSrc=1, ALUOp=00.
- 000100 beq: Branch=1, ALUOp=01.
- Any other opcode: all controls 0; illegal_op=1 when if_valid=1.

Hazard detection (combinational):
- load_use = id_valid & m_MemRead_out & (rt != 0) & if_valid & (rt == instruction[25:21] | (rt == instruction[20:16] & opcode in {R-type, sw, beq})).
- stall_if = load_use & ~ex_flush.

ID/EX update at each posedge (priority top-down):
1. reset: clear as above.
2. ex_flush=1: bubble (id_valid=0, all control and illegal_op = 0; data fields don't-care, implementation loads 0).
3. stall_if=1: bubble inserted; IF must hold, so the same instruction is re-decoded next cycle.
4. Otherwise: load the decoded instruction; id_valid = if_valid. If if_valid=0, all control outputs are 0.

Other rules:
- Sign extension: bits [B-1:16] = instruction[15].
- A stall lasts exactly one cycle per load-use pair; back-to-back lw -> use -> use produces a single stall.
- Flush during a stall: the flush wins; no stall is asserted.

Test Plan:
- Reset mid-run with reset=1 for 1 cycle -> all outputs 0, id_valid=0; reading $5 afterwards returns 0.
- Write $3=0xDEADBEEF via WB while decoding add $1,$3,$0 in the same cycle -> next cycle reg_data1=0xDEADBEEF (bypass), RegWrite=1, RegDst=1, ALUOp=10.
- Write to $0 with 0x12345678, then read $0 -> reg_data1=0.
- lw $2,4($1) followed by add $4,$2,$5 -> stall_if=1 for exactly one cycle, one bubble (id_valid=0), then add issues with id_valid=1; same sequence with sw $2,0($7) also stalls; addi-style unknown opcode using rt does not stall.
- beq in ID with ex_flush=1 asserted together with a load-use stall -> stall_if=0, next cycle id_valid=0 and all controls 0.
- Decode instruction 0x8C22FFFC (lw, imm -4) -> sgn_extend_data_imm=0xFFFFFFFC, MemRead=1, MemtoReg=1, ALUSrc=1; opcode 0x3F -> illegal_op_out=1, all controls 0.
